// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus between the two writeback sources, the issue stage and the
// register-file write port. slave is the arbiter's view; master is the
// surrounding pipeline.
interface regfile_writeback_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
);
   logic                      src0_valid;
   logic                      src0_ready;
   logic [ADDR_WIDTH-1:0]     src0_address;
   logic [DATA_WIDTH-1:0]     src0_data;
   logic                      src1_valid;
   logic                      src1_ready;
   logic [ADDR_WIDTH-1:0]     src1_address;
   logic [DATA_WIDTH-1:0]     src1_data;
   logic                      rsv_valid;
   logic [ADDR_WIDTH-1:0]     rsv_address;
   logic [ADDR_WIDTH-1:0]     select_a;
   logic [ADDR_WIDTH-1:0]     select_b;
   logic                      hazard_a;
   logic                      hazard_b;
   logic                      rf_write;
   logic [ADDR_WIDTH-1:0]     rf_address;
   logic [DATA_WIDTH-1:0]     rf_data_in;
   logic [2**ADDR_WIDTH-1:0]  pending;

   modport slave (
      input  src0_valid, src0_address, src0_data,
      input  src1_valid, src1_address, src1_data,
      input  rsv_valid, rsv_address, select_a, select_b,
      output src0_ready, src1_ready, hazard_a, hazard_b,
      output rf_write, rf_address, rf_data_in, pending
   );

   modport master (
      output src0_valid, src0_address, src0_data,
      output src1_valid, src1_address, src1_data,
      output rsv_valid, rsv_address, select_a, select_b,
      input  src0_ready, src1_ready, hazard_a, hazard_b,
      input  rf_write, rf_address, rf_data_in, pending
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (src0) and load (src1) writeback paths, with a pending-write scoreboard
// that flags read hazards for the issue stage.
module regfile_writeback_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31
) (
   input logic                        clock,
   input logic                        reset,
   regfile_writeback_arbiter_if.slave bus
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   typedef enum logic {PRI_SRC0, PRI_SRC1} prio_e;

   prio_e                  prio_q, prio_d;
   logic                   grant0, grant1;
   logic [ADDR_WIDTH-1:0]  winAddress;
   logic [DATA_WIDTH-1:0]  winData;
   logic                   winWrites;
   logic                   rfWrite_q, rfWrite_d;
   logic [ADDR_WIDTH-1:0]  rfAddress_q, rfAddress_d;
   logic [DATA_WIDTH-1:0]  rfData_q, rfData_d;
   logic [NUM_REGS-1:0]    pending_q, pending_d;

   // Grant decision and priority pointer update; the pointer only moves on a grant.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      prio_d = prio_q;
      if (bus.src0_valid && bus.src1_valid) begin
         if (prio_q == PRI_SRC0) begin
            grant0 = 1'b1;
         end else begin
            grant1 = 1'b1;
         end
      end else begin
         grant0 = bus.src0_valid;
         grant1 = bus.src1_valid;
      end
      if (grant0) begin
         prio_d = PRI_SRC1;
      end else if (grant1) begin
         prio_d = PRI_SRC0;
      end
   end

   // Select the winning request; writes to the zero register are accepted but dropped.
   always_comb begin
      winAddress = grant1 ? bus.src1_address : bus.src0_address;
      winData    = grant1 ? bus.src1_data    : bus.src0_data;
      winWrites  = (grant0 || grant1) && (winAddress != ZERO_ADDR);
   end

   // Next write-port contents; address and data hold while no write is presented.
   always_comb begin
      rfWrite_d   = winWrites;
      rfAddress_d = rfAddress_q;
      rfData_d    = rfData_q;
      if (winWrites) begin
         rfAddress_d = winAddress;
         rfData_d    = winData;
      end
   end

   // Scoreboard next state: clear on completion first so a same-cycle reservation wins.
   always_comb begin
      pending_d = pending_q;
      if (winWrites) begin
         pending_d[winAddress] = 1'b0;
      end
      if (bus.rsv_valid && (bus.rsv_address != ZERO_ADDR)) begin
         pending_d[bus.rsv_address] = 1'b1;
      end
   end

   // State registers; reset drops any in-flight write and all reservations.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prio_q      <= PRI_SRC0;
         rfWrite_q   <= 1'b0;
         rfAddress_q <= '0;
         rfData_q    <= '0;
         pending_q   <= '0;
      end else begin
         prio_q      <= prio_d;
         rfWrite_q   <= rfWrite_d;
         rfAddress_q <= rfAddress_d;
         rfData_q    <= rfData_d;
         pending_q   <= pending_d;
      end
   end

   assign bus.src0_ready = grant0;
   assign bus.src1_ready = grant1;
   assign bus.rf_write   = rfWrite_q;
   assign bus.rf_address = rfAddress_q;
   assign bus.rf_data_in = rfData_q;
   assign bus.pending    = pending_q;
   assign bus.hazard_a   = pending_q[bus.select_a] && (bus.select_a != ZERO_ADDR);
   assign bus.hazard_b   = pending_q[bus.select_b] && (bus.select_b != ZERO_ADDR);

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: a reference model of the
// arbitration and scoreboard predicts each cycle, and the expected write-port
// contents are queued at grant time and compared one cycle later.
module tb_regfile_writeback_arbiter;

   typedef struct packed {
      logic        wr;
      logic [4:0]  addr;
      logic [63:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   int errors = 0;
   int checks = 0;

   exp_t        expQ[$];
   logic [31:0] mPend     = '0;
   logic        mPtr      = 1'b0;
   logic [4:0]  mLastAddr = '0;
   logic [63:0] mLastData = '0;

   regfile_writeback_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

   regfile_writeback_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(31)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Count one comparison and report it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of stimulus, check combinational outputs, predict and check the next cycle.
   task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                                input logic rv, input logic [4:0] ra,
                                input logic [4:0] sa, input logic [4:0] sb);
      exp_t        e;
      exp_t        got;
      logic        g0, g1;
      logic [4:0]  wa;
      logic [63:0] wd;
      bus.src0_valid   = v0;
      bus.src0_address = a0;
      bus.src0_data    = d0;
      bus.src1_valid   = v1;
      bus.src1_address = a1;
      bus.src1_data    = d1;
      bus.rsv_valid    = rv;
      bus.rsv_address  = ra;
      bus.select_a     = sa;
      bus.select_b     = sb;
      #1;
      checkOutput("hazard_a", 64'(bus.hazard_a), 64'(mPend[sa] && (sa != 5'd31)));
      checkOutput("hazard_b", 64'(bus.hazard_b), 64'(mPend[sb] && (sb != 5'd31)));
      g0 = v0 && (!v1 || (mPtr == 1'b0));
      g1 = v1 && (!v0 || (mPtr == 1'b1));
      checkOutput("src0_ready", 64'(bus.src0_ready), 64'(g0));
      checkOutput("src1_ready", 64'(bus.src1_ready), 64'(g1));
      wa = g1 ? a1 : a0;
      wd = g1 ? d1 : d0;
      e.wr = 1'b0;
      if ((g0 || g1) && (wa != 5'd31)) begin
         e.wr      = 1'b1;
         mLastAddr = wa;
         mLastData = wd;
         mPend[wa] = 1'b0;
      end
      e.addr = mLastAddr;
      e.data = mLastData;
      if (rv && (ra != 5'd31)) mPend[ra] = 1'b1;
      if (g0) mPtr = 1'b1;
      else if (g1) mPtr = 1'b0;
      expQ.push_back(e);
      @(posedge clock);
      @(negedge clock);
      checkOutput("expect_queue", 64'(expQ.size()), 64'd1);
      if (expQ.size() > 0) begin
         got = expQ.pop_front();
         checkOutput("rf_write", 64'(bus.rf_write), 64'(got.wr));
         checkOutput("rf_address", 64'(bus.rf_address), 64'(got.addr));
         checkOutput("rf_data_in", bus.rf_data_in, got.data);
      end
      checkOutput("pending", 64'(bus.pending), 64'(mPend));
   endtask

   // Return every input to idle.
   task automatic idleInputs();
      bus.src0_valid   = 1'b0;
      bus.src0_address = '0;
      bus.src0_data    = '0;
      bus.src1_valid   = 1'b0;
      bus.src1_address = '0;
      bus.src1_data    = '0;
      bus.rsv_valid    = 1'b0;
      bus.rsv_address  = '0;
      bus.select_a     = '0;
      bus.select_b     = '0;
   endtask

   // Main test sequence.
   initial begin
      idleInputs();
      #1;
      checkOutput("reset_rf_write", 64'(bus.rf_write), 64'd0);
      checkOutput("reset_rf_address", 64'(bus.rf_address), 64'd0);
      checkOutput("reset_rf_data_in", bus.rf_data_in, 64'd0);
      checkOutput("reset_pending", 64'(bus.pending), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Idle after reset release
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Write in flight plus a reservation of r4, then reset asynchronously mid-stream
      applyStimulus(1, 5'd2, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, 1, 5'd4, 0, 0);
      checkOutput("pre_reset_pending", 64'(bus.pending), 64'h10);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rf_write", 64'(bus.rf_write), 64'd0);
      checkOutput("async_pending", 64'(bus.pending), 64'd0);
      checkOutput("async_rf_address", 64'(bus.rf_address), 64'd0);
      mPend = '0;
      mPtr = 1'b0;
      mLastAddr = '0;
      mLastData = '0;
      expQ.delete();
      idleInputs();
      @(negedge clock);
      reset = 1'b1;

      // src0 only
      applyStimulus(1, 5'd3, 64'h1122334455667788, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("src0_addr3", 64'(bus.rf_address), 64'd3);
      checkOutput("src0_data", bus.rf_data_in, 64'h1122334455667788);

      // Zero register via src1, plus a reservation of r31
      applyStimulus(0, 0, 0, 1, 5'd31, 64'hDEAD_BEEF_0000_0031, 1, 5'd31, 5'd31, 5'd31);
      checkOutput("zero_no_write", 64'(bus.rf_write), 64'd0);
      checkOutput("pending31", 64'(bus.pending[31]), 64'd0);

      // Contention: both held for four cycles
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 5'd5, 64'h5555_0000_0000_0005, 1, 5'd6, 64'h6666_0000_0000_0006, 0, 0, 0, 0);
      checkOutput("contention_last_addr", 64'(bus.rf_address), 64'd6);

      // Reserve r7 and watch hazard_a rise and fall around the completing write
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd8);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
      applyStimulus(1, 5'd7, 64'h7777_7777_7777_7777, 0, 0, 0, 0, 0, 5'd7, 5'd7);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);

      // Simultaneous reservation and completion of r9
      applyStimulus(1, 5'd9, 64'h9999_0000_9999_0000, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
      checkOutput("pending9_set", 64'(bus.pending[9]), 64'd1);
      checkOutput("r9_addr", 64'(bus.rf_address), 64'd9);

      // Random traffic
      for (int i = 0; i < 40; i++)
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
